// File: rtl/vec_pkg.sv
// Shared definitions for the vector capture block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// The packed vector layout matches the 11-bit test-vector file format:
// [10:9]=op, [8:6]=a, [5:3]=b, [2:0]=z.
package vec_pkg;

  localparam int VW     = 11;
  localparam int OP_LSB = 9;
  localparam int A_LSB  = 6;
  localparam int B_LSB  = 3;
  localparam int Z_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DUMP    = 2'd2
  } state_t;

  // Field order gives op in the MSBs, so the struct packs straight into
  // the vector-file layout without any bit shuffling.
  typedef struct packed {
    logic [1:0] op;
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] z;
  } vec_t;

endpackage

// File: rtl/vec_buf_ram.sv
// Sample buffer: single-port DEPTH x VW RAM, synchronous write, registered read.
// Latency: read data appears one cycle after the address is presented.
// Backpressure: none; the caller holds the address to hold the read data.
//
// Ports:
//   clk   - clock, rising edge
//   we    - write enable for addr
//   addr  - shared read/write address
//   wdata - write data
//   rdata - registered read of addr (old contents on a same-cycle write)
//
// Contents are deliberately not reset; the owner tracks which entries are valid.
module vec_buf_ram #(
  parameter int AW = 4,
  parameter int VW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [VW-1:0] wdata,
  output logic [VW-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [VW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/vec_capture.sv
// Records live {op,a,b,z} samples into a buffer and streams them out as 11-bit vectors.
// Latency: first rd_valid 2 cycles after dump; then one entry per cycle under rd_ready.
// Backpressure: rd_valid/rd_ready; rd_data/rd_last held while rd_valid & !rd_ready.
//
// Ports:
//   clk, rst         - clock (rising edge), asynchronous active-low reset
//   start/stop       - begin (clearing the buffer) / end capture
//   cap_en           - record {op,a,b,z} this cycle while capturing
//   op, a, b, z      - snooped ALU-style unit ports
//   dump             - stream the stored entries out
//   rd_ready         - downstream accepts rd_data
//   rd_valid/rd_data - output vector, {op,a,b,z}
//   rd_last          - marks the final entry of a dump
//   count, full      - stored entry count (0..DEPTH), count == DEPTH
//   overflow         - sticky: a sample arrived while full
//   busy             - not idle
module vec_capture
  import vec_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          cap_en,
  input  logic [1:0]    op,
  input  logic [2:0]    a,
  input  logic [2:0]    b,
  input  logic [2:0]    z,
  input  logic          dump,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [VW-1:0] rd_data,
  output logic          rd_last,
  output logic [AW:0]   count,
  output logic          full,
  output logic          overflow,
  output logic          busy
);

  localparam int          DEPTH     = 1 << AW;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT   = (AW+1)'(1);

  state_t        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] idx_q, idx_d;     // index of the entry being presented on rd_data
  logic          rd_vld_q, rd_vld_d;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  vec_t          ram_wdat;
  vec_t          ram_rdat;

  logic          is_full;
  logic          last_hit;
  logic          xfer;

  assign is_full  = (count_q == DEPTH_CNT);
  assign last_hit = ({1'b0, idx_q} == (count_q - ONE_CNT));
  assign xfer     = rd_vld_q & rd_ready;
  assign ram_wdat = '{op: op, a: a, b: b, z: z};

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    idx_d    = idx_q;
    rd_vld_d = rd_vld_q;
    ram_we   = 1'b0;
    ram_addr = idx_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CAPTURE;
          count_d = '0;
          ovf_d   = 1'b0;
        end else if (dump && (count_q != '0)) begin
          state_d  = DUMP;
          idx_d    = '0;
          rd_vld_d = 1'b0;
        end
      end

      CAPTURE: begin
        ram_addr = count_q[AW-1:0];
        if (start) begin
          // Restart: a same-cycle sample becomes entry 0 of the new capture.
          ram_addr = '0;
          ovf_d    = 1'b0;
          count_d  = '0;
          if (cap_en) begin
            ram_we  = 1'b1;
            count_d = ONE_CNT;
          end
        end else begin
          if (cap_en) begin
            if (!is_full) begin
              ram_we  = 1'b1;
              count_d = count_q + ONE_CNT;
            end else begin
              ovf_d = 1'b1;
            end
          end
          if (stop) begin
            state_d = IDLE;
          end
        end
      end

      DUMP: begin
        // Prefetch the next entry on a transfer; otherwise keep re-reading
        // the current one so the registered RAM output stays stable.
        ram_addr = xfer ? (idx_q + 1'b1) : idx_q;
        if (!rd_vld_q) begin
          // Only the first DUMP cycle sees rd_valid low: entry 0 is being read.
          rd_vld_d = 1'b1;
        end else if (xfer) begin
          if (last_hit) begin
            rd_vld_d = 1'b0;
            state_d  = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      default: begin
        state_d  = IDLE;
        rd_vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      idx_q    <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      idx_q    <= idx_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  vec_buf_ram #(
    .AW (AW),
    .VW (VW)
  ) u_buf (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdat),
    .rdata (ram_rdat)
  );

  // RAM output is not reset, so qualify it with rd_valid to give clean zeros.
  assign rd_valid = rd_vld_q;
  assign rd_data  = rd_vld_q ? ram_rdat : '0;
  assign rd_last  = rd_vld_q & last_hit;
  assign count    = count_q;
  assign full     = is_full;
  assign overflow = ovf_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_vec_capture.sv
module tb_vec_capture;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic        cap_en;
  logic [1:0]  op;
  logic [2:0]  a;
  logic [2:0]  b;
  logic [2:0]  z;
  logic        dump;
  logic        rd_ready;
  logic        rd_valid;
  logic [10:0] rd_data;
  logic        rd_last;
  logic [AW:0] count;
  logic        full;
  logic        overflow;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  logic [10:0] mdl_mem [DEPTH];
  int          mdl_cnt = 0;
  int          mdl_ovf = 0;
  logic [10:0] sb [$];

  vec_capture #(.AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .cap_en   (cap_en),
    .op       (op),
    .a        (a),
    .b        (b),
    .z        (z),
    .dump     (dump),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .count    (count),
    .full     (full),
    .overflow (overflow),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start   = 1'b1;
    mdl_cnt = 0;
    mdl_ovf = 0;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_cnt", count, 0);
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_busy", busy, 0);
  endtask

  task automatic cap_one(input logic [10:0] v);
    {op, a, b, z} = v;
    cap_en = 1'b1;
    if (mdl_cnt < DEPTH) begin
      mdl_mem[mdl_cnt] = v;
      mdl_cnt++;
    end else begin
      mdl_ovf = 1;
    end
    tick();
    cap_en = 1'b0;
    check("cap_cnt", count, mdl_cnt);
    check("cap_full", full, (mdl_cnt == DEPTH) ? 1 : 0);
    check("cap_ovf", overflow, mdl_ovf);
  endtask

  task automatic run_dump(input logic [3:0] pat);
    int          first_i;
    int          last_i;
    int          n_xfer;
    bit          stalled;
    bit          done;
    logic [10:0] held;
    logic        held_last;
    logic [10:0] exp;
    for (int k = 0; k < mdl_cnt; k++) sb.push_back(mdl_mem[k]);
    dump = 1'b1;
    tick();
    dump = 1'b0;
    first_i = -1; last_i = -1; n_xfer = 0; stalled = 0; done = 0;
    held = '0; held_last = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (stalled) begin
        check("hold_vld", rd_valid, 1);
        check("hold_dat", rd_data, held);
        check("hold_last", rd_last, held_last);
        stalled = 0;
      end
      if (rd_valid && first_i < 0) first_i = i;
      rd_ready = pat[i % 4];
      if (rd_valid && rd_ready) begin
        n_xfer++;
        if (sb.size() == 0) begin
          check("extra_xfer", n_xfer, mdl_cnt);
        end else begin
          exp = sb.pop_front();
          check("dump_dat", rd_data, exp);
          check("dump_last", rd_last, (sb.size() == 0) ? 1 : 0);
          if (sb.size() == 0) begin
            done   = 1;
            last_i = i;
          end
        end
      end else if (rd_valid) begin
        held      = rd_data;
        held_last = rd_last;
        stalled   = 1;
      end
      tick();
    end
    rd_ready = 1'b0;
    check("dump_done", done, 1);
    check("first_vld", first_i, 1);
    check("n_xfer", n_xfer, mdl_cnt);
    check("post_vld", rd_valid, 0);
    check("post_busy", busy, 0);
    if (pat == 4'hF) check("burst_len", last_i, mdl_cnt);
    sb.delete();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; cap_en = 1'b0; dump = 1'b0;
    rd_ready = 1'b0; op = '0; a = '0; b = '0; z = '0;
    #2;
    check("rst_vld", rd_valid, 0);
    check("rst_dat", rd_data, 0);
    check("rst_last", rd_last, 0);
    check("rst_cnt", count, 0);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);
    #10 rst = 1'b1;
    tick();

    // Basic capture of three vectors, continuous dump.
    pulse_start();
    cap_one(11'b01_011_010_101);
    cap_one(11'b10_111_001_110);
    cap_one(11'b00_000_000_000);
    pulse_stop();
    check("t1_cnt", count, 3);
    run_dump(4'hF);

    // Fill past capacity: full after the 4th, overflow after the 5th.
    pulse_start();
    for (int i = 0; i < 6; i++) cap_one(11'(i * 173 + 5));
    pulse_stop();
    run_dump(4'hF);

    // Stalling consumer on the same contents.
    run_dump(4'b1001);

    // Asynchronous reset two cycles into a dump.
    check("pre_full", full, 1);
    dump = 1'b1;
    tick();
    dump = 1'b0;
    rd_ready = 1'b0;
    tick();
    tick();
    check("pre_vld", rd_valid, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_vld", rd_valid, 0);
    check("arst_cnt", count, 0);
    check("arst_busy", busy, 0);
    check("arst_full", full, 0);
    #2 rst = 1'b1;
    mdl_cnt = 0;
    mdl_ovf = 0;
    tick();

    // Dump with an empty buffer is ignored.
    dump = 1'b1;
    tick();
    dump = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("empty_vld", rd_valid, 0);
      check("empty_busy", busy, 0);
      tick();
    end

    // start and dump together: start wins.
    start = 1'b1;
    dump  = 1'b1;
    mdl_cnt = 0;
    mdl_ovf = 0;
    tick();
    start = 1'b0;
    dump  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("sd_busy", busy, 1);
      check("sd_vld", rd_valid, 0);
      tick();
    end
    pulse_stop();

    // Same two-entry capture dumped twice.
    pulse_start();
    cap_one(11'b11_101_010_011);
    cap_one(11'b01_110_100_001);
    pulse_stop();
    run_dump(4'hF);
    run_dump(4'b0101);

    // Restart mid-capture with a same-cycle sample.
    pulse_start();
    cap_one(11'b10_001_001_010);
    cap_one(11'b00_111_111_111);
    {op, a, b, z} = 11'b11_010_110_100;
    start  = 1'b1;
    cap_en = 1'b1;
    mdl_cnt = 0;
    mdl_ovf = 0;
    mdl_mem[0] = 11'b11_010_110_100;
    mdl_cnt = 1;
    tick();
    start  = 1'b0;
    cap_en = 1'b0;
    check("rs_cnt", count, 1);
    check("rs_busy", busy, 1);
    pulse_stop();
    run_dump(4'hF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vec_capture.md
Name: vec_capture

Overview:
- Hardware-side counterpart of the team's vector-driven benches: instead of applying stored vectors to the ALU-style unit under test, it records live {op, A, B, Z} samples into an on-chip buffer.
- It later streams the samples out over a valid/ready port in exactly the 11-bit test-vector layout, so dumps can be replayed as golden .tv files.
- Sits beside the op/A/B→Z unit, snooping its ports.

Parameters:
AW, 4, buffer address width; DEPTH = 2**AW entries
VW, 11, vector width (2 op + 3 A + 3 B + 3 Z); fixed, not to be overridden

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  pulse: clear buffer and begin capture
stop  input  1  pulse: end capture
cap_en  input  1  sample qualifier; record one vector this cycle
op  input  2  snooped opcode
a  input  3  snooped operand A
b  input  3  snooped operand B
z  input  3  snooped result Z
dump  input  1  pulse: stream buffer contents out
rd_ready  input  1  downstream accepts rd_data
rd_valid  output  1  rd_data holds a valid entry
rd_data  output  11  {op,a,b,z}: [10:9]=op, [8:6]=a, [5:3]=b, [2:0]=z
rd_last  output  1  qualifies final entry of a dump
count  output  AW+1  number of stored entries, 0..DEPTH
full  output  1  count == DEPTH
overflow  output  1  sticky: cap_en seen while full
busy  output  1  state != IDLE

Behaviour:
- Reset (rst=0, async), all outputs 0: rd_valid, rd_data, rd_last, count, full, overflow, busy. State=IDLE; write/read pointers=0. RAM contents are not reset (don't-care).
- FSM states: IDLE, CAPTURE, DUMP.
- IDLE:
  - start → CAPTURE next cycle; count and overflow cleared.
  - dump with count>0 → DUMP, rd_ptr=0. dump with count==0 is ignored.
  - start and dump in the same cycle: start wins.
  - cap_en is ignored.
- CAPTURE:
  - Each cycle with cap_en=1 and !full: write {op,a,b,z} at address count[AW-1:0]; count+1 the following cycle. One write per cycle; back-to-back writes supported.
  - count reaching DEPTH sets full; state stays CAPTURE until stop.
  - cap_en while full: no write, overflow←1, sticky until next start or reset.
  - stop → IDLE. A cap_en in the same cycle as stop is still recorded.
  - start while in CAPTURE restarts: count←0, overflow←0, state stays CAPTURE. A same-cycle cap_en is written at address 0, so count=1 next cycle.
  - dump is ignored.
- DUMP:
  - First rd_valid rises 2 cycles after the dump pulse (1 cycle state entry, 1 cycle registered RAM read).
  - Transfer occurs on rd_valid & rd_ready. Next entry is valid the cycle after transfer (read prefetch), giving one entry per cycle under continuous rd_ready.
  - rd_data and rd_last are held stable while rd_valid & !rd_ready.
  - rd_last=1 with the entry at index count-1.
  - After the last transfer: rd_valid←0 and state → IDLE next cycle. count and contents are preserved, so repeated dumps are allowed.
  - start, stop, cap_en and dump are ignored during DUMP.
- full and count remain valid in all states. busy=1 in CAPTURE and DUMP.
- Reset mid-capture or mid-dump aborts immediately to reset values; no partial transfer is completed.

Decomposition:
- Package vec_pkg holds:
  - VW=11
  - field LSB constants OP_LSB=9, A_LSB=6, B_LSB=3, Z_LSB=0
  - state encodings IDLE=2'd0, CAPTURE=2'd1, DUMP=2'd2
- One sub-module, vec_buf_ram: single-port, DEPTH×VW, synchronous write, registered read, no reset. Single port suffices because capture and dump never overlap.

Test Plan:
- Reset then start; cap_en for 3 cycles with {op,a,b,z}=01_011_010_101, 10_111_001_110, 00_000_000_000; stop; dump with rd_ready=1 → count=3, rd_data 01011010101, 10111001110, 00000000000 on consecutive cycles, rd_last only on the third, busy low afterwards.
- AW=2: start, then 6 consecutive cap_en samples → count=4, full=1 after the 4th, overflow=1 after the 5th; dump yields only the first 4 samples.
- Dump with rd_ready toggling 1,0,0,1 → each entry is held unchanged while stalled; no entry is lost or duplicated; exactly count transfers occur.
- dump while count==0 → rd_valid stays 0 and busy stays 0. start and dump in the same IDLE cycle → state CAPTURE, no rd_valid.
- Drive rst=0 asynchronously two cycles into a dump → rd_valid, count, busy and full are 0 immediately, before the next clk edge.
- Dump the same 2-entry capture twice → identical data both times; start with a same-cycle cap_en mid-CAPTURE → count=1 and entry 0 holds the new sample.
